fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter IM_WORDS, default 4096, instruction-memory depth in words, based at PC_RESET.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit freeze of PC and IF/RR register.
REQ-006 redirectEn  input  1  branch/jump taken, resolved in RR.
REQ-007 redirectPc  input  32  redirect target.
REQ-008 imAddr  output  12  word index into IM, (pc - PC_RESET)[13:2].
REQ-009 imInstr  input  32  combinational IM read data for imAddr.
REQ-010 pcIF  output  32  current fetch PC.
REQ-011 pcIF2RR  output  32  registered PC handed to RR.
REQ-012 instrIF2RR  output  32  registered instruction handed to RR.
REQ-013 excIF2RR  output  1  registered fetch-fault flag handed to RR.

Function
REQ-014 imAddr SHALL be combinational from pcIF; the IM read is zero-latency.
REQ-015 Fetch fault SHALL be asserted when pcIF[1:0] != 0, or pcIF < PC_RESET, or pcIF >= PC_RESET + 4*IM_WORDS.
REQ-016 On a fetch fault, instrIF2RR SHALL load 32'h0 (nop) and excIF2RR SHALL load 1; otherwise they SHALL load imInstr and 0.
REQ-017 Next PC SHALL be: redirectPc if redirectEn && !stall; pcIF if stall; pcIF + 4 otherwise (32-bit wrap, no saturation).
REQ-018 Stall SHALL hold pcIF, pcIF2RR, instrIF2RR and excIF2RR unchanged for every cycle it is high.
REQ-019 When stall and redirectEn are both high, the redirect SHALL be ignored that cycle; RR re-asserts it once unstalled.
REQ-020 Branch delay slot: on redirect, the instruction at pcIF (the slot) SHALL still enter the IF/RR register; nothing is flushed.
REQ-021 When not stalled, the IF/RR register SHALL load pcIF and the fetched instruction every cycle, giving a one-cycle latency from pcIF to pcIF2RR.
REQ-022 A misaligned redirectPc SHALL be accepted into pcIF unchanged and faulted by REQ-015 on the next fetch.

Reset
REQ-023 On reset, pcIF SHALL be PC_RESET, pcIF2RR SHALL be PC_RESET, instrIF2RR SHALL be 32'h0, and excIF2RR SHALL be 0.
REQ-024 Reset SHALL override stall and redirectEn in the same cycle.
REQ-025 The first non-reset cycle SHALL fetch PC_RESET.

Structure
REQ-026 PC_RESET, the nop encoding and the IF/RR bundle typedef (pc, instr, exc) SHALL live in the shared MACRO package.
REQ-027 The next-PC selection SHALL be a sub-module, fetch_npc (combinational).
REQ-028 The PC register and the IF/RR register SHALL be the only state elements; the IM itself stays outside this block.

Verification
REQ-029 Reset, then 3 free cycles -> pcIF steps 0x3000, 0x3004, 0x3008, 0x300C; pcIF2RR lags pcIF by one cycle; exc = 0.
REQ-030 At pcIF = 0x3008, pulse redirectEn with target 0x3100 -> pcIF2RR = 0x3008 (slot), then the next pcIF = 0x3100.
REQ-031 Stall for 2 cycles at pcIF = 0x3010 -> pcIF and IF/RR hold for 2 cycles; 0x3014 follows after stall drops.
REQ-032 stall = 1 and redirectEn = 1 (target 0x3200) together -> pcIF is unchanged; the redirect is taken the cycle after stall drops.
REQ-033 Redirect to 0x3002 and to 0x7000 -> instrIF2RR = 0, excIF2RR = 1, and PC keeps advancing by 4.
REQ-034 Assert reset mid-stall with a pending redirect -> all outputs take the REQ-023 values on the next edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, nop
// encoding, IF/RR pipeline bundle and the fetch-fault decode helper.
package fetch_unit_pkg;

   // Default PC after reset; also the base address of instruction memory.
   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

   // Default instruction-memory depth in 32-bit words.
   localparam int unsigned IM_WORDS_DEF = 4096;

   // Encoding injected into the pipeline in place of a faulting fetch.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Sequential fetch increment in bytes.
   localparam logic [31:0] PC_STEP = 32'h0000_0004;

   // Contents of the IF/RR pipeline register.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } if_rr_t;

   // Next-PC source selection.
   typedef enum logic [1:0] {
      NPC_SEQ      = 2'd0,
      NPC_HOLD     = 2'd1,
      NPC_REDIRECT = 2'd2
   } npc_sel_e;

   // A fetch faults when the PC is not word aligned or falls outside the
   // window [base, base + span). The upper bound is computed in 33 bits so
   // a window ending exactly at 2^32 does not wrap to zero.
   function automatic logic fetch_fault(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input logic [32:0] span);
      logic [32:0] limit;
      limit       = {1'b0, base} + span;
      fetch_fault = (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
   endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection for the fetch stage. A stall freezes the PC and
// swallows any redirect presented in the same cycle; RR re-presents it.
module fetch_npc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        redirect_en_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] npc_o
);

   npc_sel_e sel_s;

   // Prioritise stall over redirect over sequential fetch.
   always_comb begin
      sel_s = NPC_SEQ;
      if (stall_i) begin
         sel_s = NPC_HOLD;
      end else if (redirect_en_i) begin
         sel_s = NPC_REDIRECT;
      end else begin
         sel_s = NPC_SEQ;
      end
   end

   // Drive the selected next PC; sequential fetch wraps at 32 bits.
   always_comb begin
      npc_o = pc_i + PC_STEP;
      case (sel_s)
         NPC_SEQ:      npc_o = pc_i + PC_STEP;
         NPC_HOLD:     npc_o = pc_i;
         NPC_REDIRECT: npc_o = redirect_pc_i;
         default:      npc_o = pc_i + PC_STEP;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, zero-latency IM addressing,
// fetch-fault detection and the IF/RR pipeline register. Redirects have
// one branch delay slot: the instruction at the current PC is never flushed.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF,
   parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirectEn,
   input  logic [31:0] redirectPc,
   output logic [11:0] imAddr,
   input  logic [31:0] imInstr,
   output logic [31:0] pcIF,
   output logic [31:0] pcIF2RR,
   output logic [31:0] instrIF2RR,
   output logic        excIF2RR
);

   // Size of the instruction-memory window in bytes.
   localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) * 33'd4;

   logic [31:0] pc_d;
   logic [31:0] pc_q;
   logic [31:0] npc_s;
   logic        fault_s;
   if_rr_t      if_rr_d;
   if_rr_t      if_rr_q;

   fetch_npc u_npc (
      .pc_i          (pc_q),
      .stall_i       (stall),
      .redirect_en_i (redirectEn),
      .redirect_pc_i (redirectPc),
      .npc_o         (npc_s)
   );

   // Word index into IM relative to its base; read data returns same cycle.
   assign imAddr  = 12'((pc_q - PC_RESET) >> 2);
   assign fault_s = fetch_fault(pc_q, PC_RESET, IM_SPAN);

   // Next-state for the PC and the IF/RR bundle; a stall holds both.
   always_comb begin
      pc_d    = npc_s;
      if_rr_d = if_rr_q;
      if (stall) begin
         if_rr_d = if_rr_q;
      end else if (fault_s) begin
         if_rr_d.pc    = pc_q;
         if_rr_d.instr = NOP_INSTR;
         if_rr_d.exc   = 1'b1;
      end else begin
         if_rr_d.pc    = pc_q;
         if_rr_d.instr = imInstr;
         if_rr_d.exc   = 1'b0;
      end
   end

   // State registers; reset wins over stall and redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= PC_RESET;
         if_rr_q.pc    <= PC_RESET;
         if_rr_q.instr <= NOP_INSTR;
         if_rr_q.exc   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         if_rr_q <= if_rr_d;
      end
   end

   assign pcIF       = pc_q;
   assign pcIF2RR    = if_rr_q.pc;
   assign instrIF2RR = if_rr_q.instr;
   assign excIF2RR   = if_rr_q.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model pushes the expected
// post-edge state into a scoreboard queue as each cycle's stimulus is driven;
// the entry is popped and compared after the clock edge.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirectEn;
   logic [31:0] redirectPc;
   logic [11:0] im_addr;
   logic [31:0] im_instr;
   logic [31:0] pc_if;
   logic [31:0] pc_if2rr;
   logic [31:0] instr_if2rr;
   logic        exc_if2rr;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rr_pc;
      logic [31:0] rr_instr;
      logic        rr_exc;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state.
   logic [31:0] pc_m;
   logic [31:0] rr_pc_m;
   logic [31:0] rr_instr_m;
   logic        rr_exc_m;
   bit          model_valid;

   fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirectEn (redirectEn),
      .redirectPc (redirectPc),
      .imAddr     (im_addr),
      .imInstr    (im_instr),
      .pcIF       (pc_if),
      .pcIF2RR    (pc_if2rr),
      .instrIF2RR (instr_if2rr),
      .excIF2RR   (exc_if2rr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Distinct, recognisable contents for every IM word.
   function automatic logic [31:0] im_word(input logic [11:0] idx);
      im_word = {8'hC3, idx ^ 12'h5A5, idx};
   endfunction

   assign im_instr = im_word(im_addr);

   function automatic logic fault_m(input logic [31:0] pc);
      fault_m = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_7000);
   endfunction

   function automatic logic [11:0] idx_m(input logic [31:0] pc);
      logic [31:0] off;
      off   = pc - 32'h0000_3000;
      idx_m = off[13:2];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model, then compare after the edge.
   task automatic step(input logic rst, input logic st, input logic re, input logic [31:0] rpc);
      exp_t e;
      @(negedge clk);
      reset      = rst;
      stall      = st;
      redirectEn = re;
      redirectPc = rpc;
      #1;
      if (model_valid) check_val("im_addr", {20'h0, im_addr}, {20'h0, idx_m(pc_m)});
      if (rst) begin
         pc_m       = 32'h0000_3000;
         rr_pc_m    = 32'h0000_3000;
         rr_instr_m = 32'h0000_0000;
         rr_exc_m   = 1'b0;
      end else if (!st) begin
         rr_pc_m    = pc_m;
         rr_exc_m   = fault_m(pc_m);
         rr_instr_m = rr_exc_m ? 32'h0000_0000 : im_word(idx_m(pc_m));
         pc_m       = re ? rpc : pc_m + 32'd4;
      end
      model_valid = 1'b1;
      e.pc       = pc_m;
      e.rr_pc    = rr_pc_m;
      e.rr_instr = rr_instr_m;
      e.rr_exc   = rr_exc_m;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("pcIF", pc_if, e.pc);
      check_val("pcIF2RR", pc_if2rr, e.rr_pc);
      check_val("instrIF2RR", instr_if2rr, e.rr_instr);
      check_val("excIF2RR", {31'h0, exc_if2rr}, {31'h0, e.rr_exc});
   endtask

   initial begin
      logic [31:0] tgt;
      n_checks    = 0;
      n_errors    = 0;
      model_valid = 1'b0;
      reset       = 1'b1;
      stall       = 1'b0;
      redirectEn  = 1'b0;
      redirectPc  = 32'h0;

      // Reset, then three free cycles.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_val("rst_pc", pc_if, 32'h0000_3000);
      check_val("rst_exc", {31'h0, exc_if2rr}, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("seq_pc1", pc_if, 32'h0000_3004);
      check_val("seq_rr1", pc_if2rr, 32'h0000_3000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("seq_pc3", pc_if, 32'h0000_300C);
      check_val("seq_rr3", pc_if2rr, 32'h0000_3008);

      // Redirect at 0x3008: the slot enters IF/RR, then the target is fetched.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_3100);
      check_val("slot_rr", pc_if2rr, 32'h0000_3008);
      check_val("redir_pc", pc_if, 32'h0000_3100);

      // Two-cycle stall at 0x3010.
      step(1'b0, 1'b0, 1'b1, 32'h0000_3010);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check_val("stall_pc", pc_if, 32'h0000_3010);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("post_stall_pc", pc_if, 32'h0000_3014);

      // Redirect under stall is ignored, then taken once stall drops.
      step(1'b0, 1'b1, 1'b1, 32'h0000_3200);
      check_val("stall_redir_pc", pc_if, 32'h0000_3014);
      step(1'b0, 1'b0, 1'b1, 32'h0000_3200);
      check_val("late_redir_pc", pc_if, 32'h0000_3200);

      // Misaligned and out-of-range targets fault but keep advancing.
      step(1'b0, 1'b0, 1'b1, 32'h0000_3002);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("mis_exc", {31'h0, exc_if2rr}, 32'h1);
      check_val("mis_pc", pc_if, 32'h0000_3006);
      step(1'b0, 1'b0, 1'b1, 32'h0000_7000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("oor_exc", {31'h0, exc_if2rr}, 32'h1);
      check_val("oor_instr", instr_if2rr, 32'h0);

      // Window edges: last word valid, word below base faults, 32-bit wrap.
      step(1'b0, 1'b0, 1'b1, 32'h0000_6FFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("last_word_exc", {31'h0, exc_if2rr}, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_2FFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("below_base_exc", {31'h0, exc_if2rr}, 32'h1);
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("wrap_pc", pc_if, 32'h0000_0000);

      // Reset mid-stall with a pending redirect.
      step(1'b0, 1'b0, 1'b1, 32'h0000_3040);
      step(1'b0, 1'b1, 1'b1, 32'h0000_3300);
      step(1'b1, 1'b1, 1'b1, 32'h0000_3300);
      check_val("rst_mid_pc", pc_if, 32'h0000_3000);
      check_val("rst_mid_rr", pc_if2rr, 32'h0000_3000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("first_fetch_rr", pc_if2rr, 32'h0000_3000);

      // Random traffic.
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       tgt = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
            1:       tgt = 32'h0000_3000 + $urandom_range(0, 16383);
            2:       tgt = $urandom();
            default: tgt = 32'h0000_6FF0 + ($urandom_range(0, 7) << 2);
         endcase
         step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), tgt);
      end

      if (sb_q.size() != 0) check_val("sb_empty", sb_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
